mem_stage: RTL and testbench

//  MEM pipeline stage directly downstream of the EX/MEM register. Resolves branches (PCSrc), performs

---
 rtl/mem_stage_pkg.sv | 22 ++
 rtl/mem_stage_if.sv | 21 ++
 rtl/mem_wb_reg.sv | 21 ++
 rtl/mem_stage.sv | 139 +++++++++++++
 tb/tb_mem_stage.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: WB control bit positions,
// FSM encoding, timeout default and the timeout fill pattern.
package mem_stage_pkg;
  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  dest;
    logic        valid;
  } mem_wb_t;
endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port between the MEM stage (master) and the memory (slave).
// Handshake: once dmem_req rises, dmem_req/we/addr/wdata stay stable until a cycle in which
// dmem_ready is high; that cycle completes the access and dmem_rdata is valid only then.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. On load every field takes d; otherwise fields hold
// and only the valid bit drops, so a stalled stage emits bubbles.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  mem_wb_t d,
  output mem_wb_t q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else begin
      q.valid <= 1'b0;
    end
  end
endmodule

// File: rtl/mem_stage.sv
// MEM stage: branch resolution, word load/store over a ready-handshaked port,
// front-of-pipe stall while an access is outstanding, sticky error flag.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        valid_in,
  input  logic [1:0]  WB_in,
  input  logic        Branch_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [31:0] addResult_in,
  input  logic        ALUZero_in,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] writeData_in,
  input  logic [4:0]  muxResult_in,
  output logic        PCSrc,
  output logic [31:0] branchTarget,
  output logic        stall,
  mem_stage_if.master dmem,
  output logic [1:0]  WB_out,
  output logic [31:0] readData_out,
  output logic [31:0] ALUResult_out,
  output logic [4:0]  muxResult_out,
  output logic        valid_out,
  output logic        err,
  output state_t      state_dbg
);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             req_q, we_q;
  logic [31:0]      addr_q, wdata_q;
  logic             mem_op, misaligned, both_rw, timeout_hit;
  logic             start, load, err_set;
  logic [31:0]      rd_sel;
  mem_wb_t          wb_d, wb_q;

  assign mem_op      = valid_in & (MemRead_in | MemWrite_in);
  assign misaligned  = (ALUResult_in[1:0] != 2'b00);
  assign both_rw     = MemRead_in & MemWrite_in;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT));

  assign PCSrc        = valid_in & Branch_in & ALUZero_in & (state == IDLE);
  assign branchTarget = addResult_in;
  assign state_dbg    = state;

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    start   = 1'b0;
    load    = 1'b0;
    err_set = 1'b0;
    rd_sel  = '0;
    case (state)
      IDLE: begin
        if (mem_op && !misaligned) begin
          stall   = 1'b1;
          start   = 1'b1;
          err_set = both_rw;
          state_n = BUSY;
        end else begin
          load    = 1'b1;
          err_set = mem_op & (misaligned | both_rw);
        end
      end
      BUSY: begin
        if (dmem.dmem_ready) begin
          load    = 1'b1;
          rd_sel  = we_q ? 32'h0 : dmem.dmem_rdata;
          state_n = IDLE;
        end else if (timeout_hit) begin
          // Forced completion so a dead memory cannot hang the pipe forever.
          load    = 1'b1;
          rd_sel  = DEADBEEF;
          err_set = 1'b1;
          state_n = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_n;
      if (start) begin
        cnt     <= '0;
        req_q   <= 1'b1;
        we_q    <= MemWrite_in;
        addr_q  <= {ALUResult_in[31:2], 2'b00};
        wdata_q <= writeData_in;
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
        if (state_n == IDLE) req_q <= 1'b0;
      end
      if (err_set) err <= 1'b1;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  // A mem op only reaches MEM/WB at completion, so its valid is always 1 there.
  assign wb_d.wb         = WB_in;
  assign wb_d.read_data  = rd_sel;
  assign wb_d.alu_result = ALUResult_in;
  assign wb_d.dest       = muxResult_in;
  assign wb_d.valid      = (state == IDLE) ? valid_in : 1'b1;

  mem_wb_reg u_mem_wb (
    .clk  (Clk),
    .rst  (Rst),
    .load (load),
    .d    (wb_d),
    .q    (wb_q)
  );

  assign WB_out        = wb_q.wb;
  assign readData_out  = wb_q.read_data;
  assign ALUResult_out = wb_q.alu_result;
  assign muxResult_out = wb_q.dest;
  assign valid_out     = wb_q.valid;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, R-type, load, store, branch, misaligned,
// read+write conflict and timeout, with hand-computed expectations.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        Clk, Rst;
  logic        valid_in, Branch_in, MemRead_in, MemWrite_in, ALUZero_in;
  logic [1:0]  WB_in;
  logic [31:0] addResult_in, ALUResult_in, writeData_in;
  logic [4:0]  muxResult_in;
  logic        PCSrc, stall, valid_out, err;
  logic [31:0] branchTarget, readData_out, ALUResult_out;
  logic [1:0]  WB_out;
  logic [4:0]  muxResult_out;
  state_t      state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage_if dif ();

  mem_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
    .Clk(Clk), .Rst(Rst), .valid_in(valid_in), .WB_in(WB_in), .Branch_in(Branch_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .addResult_in(addResult_in),
    .ALUZero_in(ALUZero_in), .ALUResult_in(ALUResult_in), .writeData_in(writeData_in),
    .muxResult_in(muxResult_in), .PCSrc(PCSrc), .branchTarget(branchTarget), .stall(stall),
    .dmem(dif.master), .WB_out(WB_out), .readData_out(readData_out),
    .ALUResult_out(ALUResult_out), .muxResult_out(muxResult_out), .valid_out(valid_out),
    .err(err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_in = 0; WB_in = 2'b00; Branch_in = 0; MemRead_in = 0; MemWrite_in = 0;
    addResult_in = '0; ALUZero_in = 0; ALUResult_in = '0; writeData_in = '0;
    muxResult_in = '0;
  endtask

  task automatic drive_mem(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] wb, input logic [4:0] dest);
    valid_in = 1; MemRead_in = rd; MemWrite_in = wr; ALUResult_in = addr;
    writeData_in = data; WB_in = wb; muxResult_in = dest;
  endtask

  task automatic pulse_reset();
    Rst = 1;
    #2;
    Rst = 0;
  endtask

  initial begin
    Rst = 1;
    clear_inputs();
    dif.dmem_ready = 0;
    dif.dmem_rdata = '0;
    tick();
    tick();
    check("rst_req", 32'(dif.dmem_req), 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    Rst = 0;

    // 1: reset in the middle of an access that never gets ready
    drive_mem(1, 0, 32'h40, 32'h0, 2'b11, 5'd3);
    #1 check("t1_stall_idle", 32'(stall), 32'h1);
    tick();
    check("t1_req", 32'(dif.dmem_req), 32'h1);
    check("t1_state_busy", 32'(state_dbg), 32'(BUSY));
    tick();
    Rst = 1;
    #1;
    check("t1_req_dropped", 32'(dif.dmem_req), 32'h0);
    check("t1_state_idle", 32'(state_dbg), 32'(IDLE));
    check("t1_addr_zero", dif.dmem_addr, 32'h0);
    check("t1_wb_zero", 32'(WB_out), 32'h0);
    #1 Rst = 0;
    clear_inputs();
    tick();

    // 2: R-type passes straight through in one cycle
    valid_in = 1; WB_in = 2'b01; ALUResult_in = 32'h1234; muxResult_in = 5'd5;
    #1 check("t2_stall", 32'(stall), 32'h0);
    tick();
    check("t2_alu", ALUResult_out, 32'h1234);
    check("t2_valid", 32'(valid_out), 32'h1);
    check("t2_wb", 32'(WB_out), 32'h1);
    check("t2_dest", 32'(muxResult_out), 32'h5);
    check("t2_rdata", readData_out, 32'h0);
    clear_inputs();
    tick();
    check("t2_valid_pulse", 32'(valid_out), 32'h0);

    // 3: load, three non-ready BUSY cycles, then ready
    drive_mem(1, 0, 32'h100, 32'h0, 2'b11, 5'd7);
    tick();
    check("t3_req", 32'(dif.dmem_req), 32'h1);
    check("t3_addr", dif.dmem_addr, 32'h100);
    check("t3_we", 32'(dif.dmem_we), 32'h0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_stall_b%0d", i), 32'(stall), 32'h1);
      check($sformatf("t3_valid_b%0d", i), 32'(valid_out), 32'h0);
      tick();
    end
    dif.dmem_ready = 1; dif.dmem_rdata = 32'hCAFEF00D;
    #1 check("t3_stall_done", 32'(stall), 32'h0);
    tick();
    dif.dmem_ready = 0; dif.dmem_rdata = '0;
    clear_inputs();
    check("t3_rdata", readData_out, 32'hCAFEF00D);
    check("t3_valid", 32'(valid_out), 32'h1);
    check("t3_dest", 32'(muxResult_out), 32'h7);
    check("t3_req_low", 32'(dif.dmem_req), 32'h0);
    check("t3_err", 32'(err), 32'h0);
    tick();
    check("t3_valid_pulse", 32'(valid_out), 32'h0);

    // 4: store completes in the minimum two cycles
    drive_mem(0, 1, 32'h0C, 32'h55, 2'b00, 5'd0);
    tick();
    check("t4_we", 32'(dif.dmem_we), 32'h1);
    check("t4_wdata", dif.dmem_wdata, 32'h55);
    check("t4_addr", dif.dmem_addr, 32'h0C);
    dif.dmem_ready = 1; dif.dmem_rdata = 32'h1111_2222;
    #1 check("t4_stall_done", 32'(stall), 32'h0);
    tick();
    dif.dmem_ready = 0;
    clear_inputs();
    check("t4_valid", 32'(valid_out), 32'h1);
    check("t4_rdata_zero", readData_out, 32'h0);
    check("t4_err", 32'(err), 32'h0);
    check("t4_req_low", 32'(dif.dmem_req), 32'h0);

    // 5: branch resolution is combinational and never stalls
    valid_in = 1; Branch_in = 1; ALUZero_in = 1; addResult_in = 32'h80;
    #1;
    check("t5_pcsrc", 32'(PCSrc), 32'h1);
    check("t5_target", branchTarget, 32'h80);
    check("t5_stall", 32'(stall), 32'h0);
    ALUZero_in = 0;
    #1 check("t5_pcsrc_nz", 32'(PCSrc), 32'h0);
    clear_inputs();
    tick();

    // 6a: misaligned load never requests and flags err
    drive_mem(1, 0, 32'h102, 32'h0, 2'b11, 5'd9);
    #1 check("t6_stall", 32'(stall), 32'h0);
    tick();
    clear_inputs();
    check("t6_no_req", 32'(dif.dmem_req), 32'h0);
    check("t6_err", 32'(err), 32'h1);
    check("t6_valid", 32'(valid_out), 32'h1);
    check("t6_rdata", readData_out, 32'h0);
    tick();
    check("t6_err_sticky", 32'(err), 32'h1);

    // 6b: read+write together behaves as a store and flags err
    pulse_reset();
    #1 check("t6_err_cleared", 32'(err), 32'h0);
    drive_mem(1, 1, 32'h10, 32'hA5A5, 2'b00, 5'd0);
    tick();
    check("t6_rw_we", 32'(dif.dmem_we), 32'h1);
    check("t6_rw_err", 32'(err), 32'h1);
    dif.dmem_ready = 1;
    tick();
    dif.dmem_ready = 0;
    clear_inputs();
    check("t6_rw_rdata", readData_out, 32'h0);

    // 6c: timeout with TIMEOUT=4: counter 0..3 stalls, 4 forces completion
    pulse_reset();
    drive_mem(1, 0, 32'h200, 32'h0, 2'b11, 5'd4);
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t6_to_stall_%0d", i), 32'(stall), 32'h1);
      tick();
    end
    check("t6_to_stall_end", 32'(stall), 32'h0);
    check("t6_to_err_before", 32'(err), 32'h0);
    tick();
    clear_inputs();
    check("t6_to_rdata", readData_out, 32'hDEADBEEF);
    check("t6_to_valid", 32'(valid_out), 32'h1);
    check("t6_to_err", 32'(err), 32'h1);
    check("t6_to_req_low", 32'(dif.dmem_req), 32'h0);
    check("t6_to_state", 32'(state_dbg), 32'(IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
